// File: rtl/interconnect_arbiter.sv
// Round-robin arbiter for a shared path: registered one-hot grant plus binary
// mux select, with optional hold-time limit that forces release.
module interconnect_arbiter #(
    parameter int NUM_OF_CONTROL_SIGNALS = 2,
    parameter int MAX_HOLD               = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [(1<<NUM_OF_CONTROL_SIGNALS)-1:0] request,
    input  logic                                   transfer_done,
    output logic [(1<<NUM_OF_CONTROL_SIGNALS)-1:0] grant,
    output logic [NUM_OF_CONTROL_SIGNALS-1:0]      control_signals,
    output logic                                   grant_valid,
    output logic                                   timeout
);

    localparam int W  = NUM_OF_CONTROL_SIGNALS;
    localparam int N  = 1 << W;
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST =
        CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [W-1:0]    ctrl_q, ctrl_d;
    logic [W-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic [W-1:0]    base;
    logic [W-1:0]    cand;
    logic [W-1:0]    pick_idx;
    logic [N-1:0]    pick_oh;
    logic            found;
    logic            hold_expired;
    logic            release_now;

    // Search starts just after the base index; k == N wraps back onto base,
    // so a lone requester that was just served can win again.
    always_comb begin
        base     = (state_q == GRANTED) ? ctrl_q : ptr_q;
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = base + k[W-1:0];
            if (!found && request[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign release_now  = transfer_done || hold_expired;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ctrl_d    = ctrl_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (found) begin
                    state_d = GRANTED;
                    grant_d = pick_oh;
                    ctrl_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANTED: begin
                if (release_now) begin
                    ptr_d     = ctrl_q;
                    cnt_d     = '0;
                    timeout_d = !transfer_done;
                    if (found) begin
                        grant_d = pick_oh;
                        ctrl_d  = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ctrl_q    <= '0;
            ptr_q     <= W'(N - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ctrl_q    <= ctrl_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant           = grant_q;
    assign control_signals = ctrl_q;
    assign grant_valid     = (state_q == GRANTED);
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_interconnect_arbiter.sv
// Directed bench for interconnect_arbiter with N=4, MAX_HOLD=4.
module tb_interconnect_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic       transfer_done;
    logic [3:0] grant;
    logic [1:0] control_signals;
    logic       grant_valid;
    logic       timeout;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] c;
        logic       v;
        logic       t;
    } vec_t;

    vec_t vq[$];

    interconnect_arbiter #(
        .NUM_OF_CONTROL_SIGNALS(2),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .request(request),
        .transfer_done(transfer_done),
        .grant(grant),
        .control_signals(control_signals),
        .grant_valid(grant_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {grant, control_signals, grant_valid, timeout};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got g/c/v/t=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] req,
                       input logic done, input logic [3:0] g,
                       input logic [1:0] c, input logic v, input logic t);
        vec_t x;
        x = '{rst, req, done, g, c, v, t};
        vq.push_back(x);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        request       = 4'b0000;
        transfer_done = 1'b0;
        tick();
        tick();
        check("reset_state", 8'b0000_00_0_0);
        reset = 1'b0;

        //  rst req      done grant    c     v     t
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 1'b0, 1'b0); // done in idle
        add(0, 4'b1010, 0, 4'b0010, 2'd1, 1'b1, 1'b0); // first grant
        add(0, 4'b0000, 0, 4'b0010, 2'd1, 1'b1, 1'b0); // held after drop
        add(0, 4'b0000, 1, 4'b0000, 2'd1, 1'b0, 1'b0); // to idle, c kept
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 1'b0, 1'b0); // reset
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1'b1, 1'b0); // rr 0
        add(0, 4'b1111, 1, 4'b0010, 2'd1, 1'b1, 1'b0); // rr 1
        add(0, 4'b1111, 1, 4'b0100, 2'd2, 1'b1, 1'b0); // rr 2
        add(0, 4'b1111, 1, 4'b1000, 2'd3, 1'b1, 1'b0); // rr 3
        add(0, 4'b1111, 1, 4'b0001, 2'd0, 1'b1, 1'b0); // rr wrap 0
        add(0, 4'b0100, 1, 4'b0100, 2'd2, 1'b1, 1'b0); // grant 2
        add(0, 4'b0000, 0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(0, 4'b1011, 0, 4'b0100, 2'd2, 1'b1, 1'b0); // others ignored
        add(0, 4'b0000, 1, 4'b0000, 2'd2, 1'b0, 1'b0); // idle, c stays 2
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0); // hold cycle 1
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0); // 2
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0); // 3
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0); // 4
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b1); // forced release
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0); // pulse ends
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(0, 4'b0001, 1, 4'b0001, 2'd0, 1'b1, 1'b0); // done wins
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1'b1, 1'b1); // count restarted

        foreach (vq[i]) begin
            reset         = vq[i].rst;
            request       = vq[i].req;
            transfer_done = vq[i].done;
            tick();
            check($sformatf("vec%0d", i),
                  {vq[i].g, vq[i].c, vq[i].v, vq[i].t});
        end

        // Async reset while requester 3 holds the path
        reset         = 1'b1;
        request       = 4'b0000;
        transfer_done = 1'b0;
        tick();
        reset   = 1'b0;
        request = 4'b1000;
        tick();
        check("grant3", 8'b1000_11_1_0);
        request = 4'b1001;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 8'b0000_00_0_0);
        tick();
        check("reset_held", 8'b0000_00_0_0);
        reset = 1'b0;
        tick();
        check("post_reset_grant0", 8'b0001_00_1_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
